// File: rtl/counter_trigger_pkg.sv
// ---------------------------------------------------------------------------
// counter_trigger_pkg
// Shared definitions for the counter-based delayed trigger stage and its
// period averager: default widths, the averager state encoding and a
// saturating increment helper for the rejected-sample counter.
// No ports (package).
// ---------------------------------------------------------------------------
package counter_trigger_pkg;

    localparam int DEF_COUNTER_WIDTH = 32;
    localparam int DEF_LOG2_DEPTH    = 3;
    localparam int DEF_TOL_WIDTH     = 16;
    localparam int SUM_WIDTH         = DEF_COUNTER_WIDTH + DEF_LOG2_DEPTH;
    localparam int REJ_CNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Counter that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [REJ_CNT_WIDTH-1:0] satInc(input logic [REJ_CNT_WIDTH-1:0] value);
        return (value == '1) ? value : value + REJ_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/period_ring_buffer.sv
// ---------------------------------------------------------------------------
// period_ring_buffer
// N x COUNTER_WIDTH sample store for the sliding window. The read is
// registered (distributed-RAM style); the averager reads the oldest entry
// at the write pointer and overwrites the same address one cycle later.
// Contents are not reset: the FILL phase writes every entry before the
// LOCKED phase ever subtracts one.
// Ports:
//   clk        clock
//   rd_en_i    capture mem[rd_addr_i] into rd_data_o on this edge
//   rd_addr_i  read address
//   wr_en_i    write wr_data_i at wr_addr_i on this edge
//   wr_addr_i  write address
//   wr_data_i  sample to store
//   rd_data_o  registered read data
// ---------------------------------------------------------------------------
module period_ring_buffer
    import counter_trigger_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int LOG2_DEPTH    = DEF_LOG2_DEPTH
) (
    input  logic                     clk,
    input  logic                     rd_en_i,
    input  logic [LOG2_DEPTH-1:0]    rd_addr_i,
    input  logic                     wr_en_i,
    input  logic [LOG2_DEPTH-1:0]    wr_addr_i,
    input  logic [COUNTER_WIDTH-1:0] wr_data_i,
    output logic [COUNTER_WIDTH-1:0] rd_data_o
);

    localparam int Depth = 1 << LOG2_DEPTH;

    logic [COUNTER_WIDTH-1:0] mem_q [Depth];
    logic [COUNTER_WIDTH-1:0] rdData_q;

    // Write port and registered read port share the clock; a read and a
    // write to the same address never happen on the same edge because the
    // averager only reads when its update pipe is empty.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rdData_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/counter_period_averager.sv
// ---------------------------------------------------------------------------
// counter_period_averager
// Sliding-window mean of the full-period counts produced by the delayed
// trigger stage, fed back to it as reference_counter. Samples are gathered
// in FILL until the window holds N of them, then the running sum is kept
// up to date in LOCKED with outlier rejection; N outliers in a row mean the
// input frequency has moved, so the window is flushed and refilled.
// Ports:
//   clk                  clock
//   aresetn              synchronous active-low reset
//   enable_i             0 holds the block in IDLE with all state cleared
//   clear_i              synchronous flush back to FILL
//   period_valid_i       one-cycle strobe, period_in_i holds a new period
//   period_in_i          period sample
//   tolerance_i          max deviation accepted when LOCKED (0 = any)
//   reference_counter_o  averaged period (last sample while filling)
//   locked_o             window full, mean valid
//   fill_count_o         accepted samples in the window, 0..N
//   rejected_count_o     saturating count of dropped samples
// ---------------------------------------------------------------------------
module counter_period_averager
    import counter_trigger_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int LOG2_DEPTH    = DEF_LOG2_DEPTH,
    parameter int TOL_WIDTH     = DEF_TOL_WIDTH
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     period_valid_i,
    input  logic [COUNTER_WIDTH-1:0] period_in_i,
    input  logic [TOL_WIDTH-1:0]     tolerance_i,
    output logic [COUNTER_WIDTH-1:0] reference_counter_o,
    output logic                     locked_o,
    output logic [LOG2_DEPTH:0]      fill_count_o,
    output logic [REJ_CNT_WIDTH-1:0] rejected_count_o
);

    localparam int SumWidth = COUNTER_WIDTH + LOG2_DEPTH;
    localparam int Depth    = 1 << LOG2_DEPTH;

    state_e                     state_q,     state_d;
    logic                       s1Valid_q,   s1Valid_d;
    logic [COUNTER_WIDTH-1:0]   s1Sample_q,  s1Sample_d;
    logic                       s2Valid_q,   s2Valid_d;
    logic [LOG2_DEPTH-1:0]      ptr_q,       ptr_d;
    logic [SumWidth-1:0]        sum_q,       sum_d;
    logic [LOG2_DEPTH:0]        fillInt_q,   fillInt_d;
    logic [COUNTER_WIDTH-1:0]   last_q,      last_d;
    logic [LOG2_DEPTH:0]        consecRej_q, consecRej_d;
    logic [REJ_CNT_WIDTH-1:0]   rejCount_q,  rejCount_d;
    logic [COUNTER_WIDTH-1:0]   reference_q, reference_d;
    logic                       locked_q,    locked_d;
    logic [LOG2_DEPTH:0]        fillCount_q, fillCount_d;

    logic                       rdEn;
    logic                       wrEn;
    logic [COUNTER_WIDTH-1:0]   oldest;
    logic                       qualified;
    logic                       busy;
    logic [COUNTER_WIDTH:0]     deviation;
    logic [COUNTER_WIDTH:0]     tolExt;
    logic                       outOfTol;
    logic [COUNTER_WIDTH-1:0]   mean;

    period_ring_buffer #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .LOG2_DEPTH    (LOG2_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rd_en_i   (rdEn),
        .rd_addr_i (ptr_q),
        .wr_en_i   (wrEn),
        .wr_addr_i (ptr_q),
        .wr_data_i (s1Sample_q),
        .rd_data_o (oldest)
    );

    // Zero periods are glitches from the trigger stage, not measurements.
    assign qualified = period_valid_i && (period_in_i != '0);
    assign busy      = s1Valid_q || s2Valid_q;

    // One extra bit so the absolute difference of two full-scale counts fits.
    assign deviation = (period_in_i >= reference_q)
                     ? {1'b0, period_in_i - reference_q}
                     : {1'b0, reference_q - period_in_i};
    assign tolExt    = (COUNTER_WIDTH+1)'(tolerance_i);
    assign outOfTol  = (tolerance_i != '0) && (deviation > tolExt);

    // Dividing by N is just dropping the low LOG2_DEPTH bits of the sum.
    assign mean = sum_q[SumWidth-1:LOG2_DEPTH];

    // Next-state logic. Stage 1 qualifies a sample and starts the ring read;
    // stage 2 folds it into the sum and overwrites the oldest entry; the
    // output registers then follow the updated state one cycle later.
    always_comb begin
        state_d     = state_q;
        s1Valid_d   = 1'b0;
        s1Sample_d  = s1Sample_q;
        s2Valid_d   = s1Valid_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        fillInt_d   = fillInt_q;
        last_d      = last_q;
        consecRej_d = consecRej_q;
        rejCount_d  = rejCount_q;
        reference_d = reference_q;
        locked_d    = locked_q;
        fillCount_d = fillCount_q;
        rdEn        = 1'b0;
        wrEn        = 1'b0;

        if (state_q == IDLE) begin
            state_d = FILL;
        end

        if (s1Valid_q) begin
            wrEn   = 1'b1;
            last_d = s1Sample_q;
            ptr_d  = ptr_q + LOG2_DEPTH'(1);
            if (state_q == LOCKED) begin
                sum_d = sum_q + SumWidth'(s1Sample_q) - SumWidth'(oldest);
            end else begin
                sum_d     = sum_q + SumWidth'(s1Sample_q);
                fillInt_d = fillInt_q + (LOG2_DEPTH+1)'(1);
                if (fillInt_q == (LOG2_DEPTH+1)'(Depth - 1)) begin
                    state_d = LOCKED;
                end
            end
        end

        reference_d = (state_q == LOCKED) ? mean : last_q;
        locked_d    = (state_q == LOCKED);
        fillCount_d = fillInt_q;

        // Intake never overlaps stage 2: a new sample only enters when the
        // pipe is empty, so the relock flush cannot collide with an update.
        if (qualified && (state_q != IDLE)) begin
            if (busy) begin
                rejCount_d = satInc(rejCount_q);
            end else if ((state_q == LOCKED) && outOfTol) begin
                rejCount_d = satInc(rejCount_q);
                if (consecRej_q == (LOG2_DEPTH+1)'(Depth - 1)) begin
                    state_d     = FILL;
                    sum_d       = '0;
                    ptr_d       = '0;
                    fillInt_d   = '0;
                    last_d      = '0;
                    consecRej_d = '0;
                    reference_d = '0;
                    locked_d    = 1'b0;
                    fillCount_d = '0;
                end else begin
                    consecRej_d = consecRej_q + (LOG2_DEPTH+1)'(1);
                end
            end else begin
                s1Valid_d   = 1'b1;
                s1Sample_d  = period_in_i;
                rdEn        = 1'b1;
                consecRej_d = '0;
            end
        end
    end

    // State register. Reset, enable low and clear all wipe everything,
    // including a sample still in the pipe; only an enabled clear lands in
    // FILL directly.
    always_ff @(posedge clk) begin
        if (!aresetn || !enable_i || clear_i) begin
            state_q     <= (aresetn && enable_i) ? FILL : IDLE;
            s1Valid_q   <= 1'b0;
            s1Sample_q  <= '0;
            s2Valid_q   <= 1'b0;
            ptr_q       <= '0;
            sum_q       <= '0;
            fillInt_q   <= '0;
            last_q      <= '0;
            consecRej_q <= '0;
            rejCount_q  <= '0;
            reference_q <= '0;
            locked_q    <= 1'b0;
            fillCount_q <= '0;
        end else begin
            state_q     <= state_d;
            s1Valid_q   <= s1Valid_d;
            s1Sample_q  <= s1Sample_d;
            s2Valid_q   <= s2Valid_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            fillInt_q   <= fillInt_d;
            last_q      <= last_d;
            consecRej_q <= consecRej_d;
            rejCount_q  <= rejCount_d;
            reference_q <= reference_d;
            locked_q    <= locked_d;
            fillCount_q <= fillCount_d;
        end
    end

    assign reference_counter_o = reference_q;
    assign locked_o            = locked_q;
    assign fill_count_o        = fillCount_q;
    assign rejected_count_o    = rejCount_q;

endmodule

// File: tb/tb_counter_period_averager.sv
// ---------------------------------------------------------------------------
// tb_counter_period_averager
// Directed bench for counter_period_averager: fill/lock, sliding mean,
// outlier rejection, relock, busy/zero samples, reset and clear.
// ---------------------------------------------------------------------------
module tb_counter_period_averager;

    logic        clk;
    logic        aresetn;
    logic        enable;
    logic        clear;
    logic        periodValid;
    logic [31:0] periodIn;
    logic [15:0] tolerance;
    logic [31:0] referenceCounter;
    logic        locked;
    logic [3:0]  fillCount;
    logic [15:0] rejectedCount;

    int checks   = 0;
    int failures = 0;

    counter_period_averager dut (
        .clk                 (clk),
        .aresetn             (aresetn),
        .enable_i            (enable),
        .clear_i             (clear),
        .period_valid_i      (periodValid),
        .period_in_i         (periodIn),
        .tolerance_i         (tolerance),
        .reference_counter_o (referenceCounter),
        .locked_o            (locked),
        .fill_count_o        (fillCount),
        .rejected_count_o    (rejectedCount)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One-cycle period strobe; returns 1 ns after the edge that samples it.
    task automatic applyStimulus(input logic [31:0] value);
        @(posedge clk); #1;
        periodValid = 1'b1;
        periodIn    = value;
        @(posedge clk); #1;
        periodValid = 1'b0;
    endtask

    // Eight well-spaced samples of one value, then let the pipe drain.
    task automatic fillWith(input logic [31:0] value);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(value);
            repeat (4) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Pulse a synchronous clear for one cycle.
    task automatic pulseClear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        aresetn     = 1'b0;
        enable      = 1'b0;
        clear       = 1'b0;
        periodValid = 1'b0;
        periodIn    = '0;
        tolerance   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ref",    referenceCounter, 32'd0);
        checkOutput("rst_locked", {31'd0, locked},  32'd0);
        checkOutput("rst_fill",   {28'd0, fillCount}, 32'd0);
        checkOutput("rst_rej",    {16'd0, rejectedCount}, 32'd0);

        aresetn = 1'b1;
        enable  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1. Fill and lock at 1000, with exact output latency.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(32'd1000);
            @(posedge clk); #1;
            checkOutput("fill_lat_count", {28'd0, fillCount}, 32'(i - 1));
            checkOutput("fill_lat_locked", {31'd0, locked}, 32'd0);
            @(posedge clk); #1;
            checkOutput("fill_count", {28'd0, fillCount}, 32'(i));
            checkOutput("fill_ref", referenceCounter, 32'd1000);
            checkOutput("fill_locked", {31'd0, locked}, (i == 8) ? 32'd1 : 32'd0);
            repeat (5) @(posedge clk);
        end

        // 2. Sliding mean: each 1008 raises the mean by one.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(32'd1008);
            repeat (2) @(posedge clk);
            #1;
            checkOutput("slide_ref", referenceCounter, 32'(1000 + k));
            repeat (2) @(posedge clk);
        end
        checkOutput("slide_locked", {31'd0, locked}, 32'd1);

        // 3. Outlier rejected, in-tolerance sample accepted.
        pulseClear();
        fillWith(32'd1000);
        tolerance = 16'd50;
        applyStimulus(32'd1100);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("outlier_ref", referenceCounter, 32'd1000);
        checkOutput("outlier_rej", {16'd0, rejectedCount}, 32'd1);
        applyStimulus(32'd1040);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("outlier_accept_ref", referenceCounter, 32'd1005);

        // 4. Eight consecutive outliers force a relock.
        pulseClear();
        fillWith(32'd1000);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(32'd2000);
            if (k == 7) begin
                checkOutput("relock_7_locked", {31'd0, locked}, 32'd1);
                checkOutput("relock_7_rej", {16'd0, rejectedCount}, 32'd7);
            end
            if (k == 8) begin
                checkOutput("relock_locked", {31'd0, locked}, 32'd0);
                checkOutput("relock_fill", {28'd0, fillCount}, 32'd0);
                checkOutput("relock_rej", {16'd0, rejectedCount}, 32'd8);
            end
            repeat (2) @(posedge clk);
        end
        fillWith(32'd2000);
        checkOutput("relock_ref", referenceCounter, 32'd2000);
        checkOutput("relock_relocked", {31'd0, locked}, 32'd1);
        checkOutput("relock_rej_kept", {16'd0, rejectedCount}, 32'd8);

        // 5. Back-to-back samples: second dropped; zero sample ignored.
        tolerance = 16'd0;
        @(posedge clk); #1;
        periodValid = 1'b1;
        periodIn    = 32'd2008;
        @(posedge clk); #1;
        periodIn    = 32'd2400;
        @(posedge clk); #1;
        periodValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy_ref", referenceCounter, 32'd2001);
        checkOutput("busy_rej", {16'd0, rejectedCount}, 32'd9);
        checkOutput("busy_fill", {28'd0, fillCount}, 32'd8);
        applyStimulus(32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("zero_rej", {16'd0, rejectedCount}, 32'd9);
        checkOutput("zero_ref", referenceCounter, 32'd2001);

        // 6. Reset one cycle after an accepted sample discards it.
        applyStimulus(32'd2800);
        aresetn = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_ref", referenceCounter, 32'd0);
        checkOutput("midrst_locked", {31'd0, locked}, 32'd0);
        checkOutput("midrst_fill", {28'd0, fillCount}, 32'd0);
        checkOutput("midrst_rej", {16'd0, rejectedCount}, 32'd0);
        aresetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midrst_after_ref", referenceCounter, 32'd0);
        checkOutput("midrst_after_fill", {28'd0, fillCount}, 32'd0);

        // Clear while LOCKED, then a sample right away proves it lands in FILL.
        fillWith(32'd1000);
        checkOutput("clear_pre_locked", {31'd0, locked}, 32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checkOutput("clear_ref", referenceCounter, 32'd0);
        checkOutput("clear_locked", {31'd0, locked}, 32'd0);
        checkOutput("clear_fill", {28'd0, fillCount}, 32'd0);
        periodValid = 1'b1;
        periodIn    = 32'd1234;
        @(posedge clk); #1;
        periodValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("clear_fill_after", {28'd0, fillCount}, 32'd1);
        checkOutput("clear_ref_after", referenceCounter, 32'd1234);

        // Dropping enable clears everything.
        enable = 1'b0;
        @(posedge clk); #1;
        checkOutput("disable_ref", referenceCounter, 32'd0);
        checkOutput("disable_fill", {28'd0, fillCount}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
